equation_checker: RTL
=====================

// Module: equation_checker
// PURPOSE
//  Produces the three arithmetic equations of a round and grades the player's answers.
//  Sits directly upstream of the top control FSM's EQUATION_1..3 states: it drives `correct` and `Wrong`.
//  It also drives operands and opcode to the display path.
//  The answer is read from the DataIn switches when the Go key is pressed.
// PARAMETERS
//  DATA_W   7        answer / operand width (switch count)
//  NUM_EQ   3        equations per round
//  SEED     16'hACE1 LFSR reset value, must be nonzero
// PORTS
//  Clock       in   1       system clock, all state on posedge
//  Resetn      in   1       asynchronous, active-low reset
//  Start       in   1       level; high begins or restarts a round (sampled each clock)
//  Enable      in   1       high while control FSM is in an EQUATION state
//  Go          in   1       raw KEY, active-low, asynchronous to Clock
//  DataIn      in   DATA_W  player answer from switches
//  OpA, OpB    out  DATA_W  current operands, for display
//  OpCode      out  2       00 add, 01 subtract, 10 multiply
//  EqNum       out  2       index of current equation, 0..NUM_EQ-1
//  correct     out  1       one-cycle pulse: answer matched
//  WrongPulse  out  1       one-cycle pulse: answer mismatched
//  Wrong       out  1       sticky: at least one wrong attempt this round
//  WrongCount  out  4       wrong attempts this round, saturates at 15
//  RoundDone   out  1       one-cycle pulse, coincident with final `correct`
// BEHAVIOUR
//  Reset (Resetn=0, async)
//   - All outputs 0; state IDLE; LFSR = SEED.
//  LFSR
//   - 16-bit Fibonacci LFSR, taps 16,14,13,11.
//   - Advances every clock in every state.
//  States: IDLE, GEN, WAIT_GO, CHECK, FINISHED
//   - IDLE: Start=1 -> GEN; clear EqNum, Wrong, WrongCount.
//   - GEN (1 cycle): sample the LFSR; op = lfsr[1:0], with 11 mapped to 00.
//     - ADD: A = lfsr[7:2], B = lfsr[13:8].
//     - SUB: same fields; swap so that A >= B.
//     - MUL: a = lfsr[5:2], b = lfsr[11:8]; a value >= 12 has 4 subtracted.
//     - Register OpA/OpB/OpCode and Expected (<= 126, fits DATA_W). -> WAIT_GO.
//   - WAIT_GO: on go_fall & Enable, latch DataIn -> CHECK.
//     - go_fall with Enable=0 is discarded (no queuing).
//   - CHECK (1 cycle): compare the latched answer with Expected.
//     - Match, EqNum < NUM_EQ-1: pulse `correct`, EqNum++ -> GEN.
//     - Match, EqNum = NUM_EQ-1: pulse `correct` and RoundDone -> FINISHED.
//     - Mismatch: pulse WrongPulse, set Wrong, WrongCount++ (saturating).
//       Return to WAIT_GO with the same operands.
//   - FINISHED: hold outputs; Start=1 -> GEN with counters cleared.
//  Go handling
//   - 2-flop synchroniser, then a falling-edge detect.
//   - Key held low yields exactly one go_fall.
//  Latency
//   - First clock edge sampling Go=0 is edge k; correct/WrongPulse is high for the cycle after edge k+3.
//  Start override
//   - Start=1 in any state other than IDLE/FINISHED restarts the round: -> GEN, counters cleared.
//   - Start beats a simultaneous go_fall.
//  Pulse behaviour
//   - correct and WrongPulse are never high together.
//   - Pulses are registered outputs (glitch-free).
//  Reset mid-round: immediate return to IDLE; no pulse is emitted.
// STRUCTURE
//  Shared include mathrix_defs.vh
//   - OpCode localparams OP_ADD/OP_SUB/OP_MUL.
//   - Checker state encodings.
//   - NUM_EQ default.
//  One sub-module: go_key_sync (sync flops plus edge detect, output go_fall).
//   - Reused later for other KEY inputs.
//  Everything else, including the LFSR, is inline.
// TESTING
//  1 Reset
//    - Resetn=0 mid-WAIT_GO -> all outputs 0 that cycle.
//    - After release, OpA/OpB stay 0 until Start.
//  2 ADD correct
//    - Start; display shows ADD 23,9; DataIn=32; Go low 5 cycles -> one `correct` pulse at edge k+3.
//    - EqNum goes 0->1; Wrong stays 0.
//  3 Wrong then right
//    - On SUB 40,17: DataIn=20 -> WrongPulse; Wrong=1, WrongCount=1; operands unchanged.
//    - Then DataIn=23 -> `correct`; Wrong stays 1.
//  4 Full round
//    - Answer all three equations correctly -> third `correct` coincides with RoundDone.
//    - State FINISHED; further Go presses produce no pulses.
//  5 Gating and races
//    - Go pressed with Enable=0 -> no pulse, even after Enable rises.
//    - Start and go_fall in the same cycle -> GEN, EqNum=0, no pulse.
//  6 Saturation and MUL bounds
//    - 17 wrong answers -> WrongCount=15.
//    - Over 1000 generated equations, assert the MUL operands are <= 11 and every Expected is <= 126.

Source files
------------

// File: rtl/equation_checker_pkg.sv
// equation_checker_pkg: opcodes, checker states and equation generation shared by the checker files
package equation_checker_pkg;
  localparam int DATA_W_DEF = 7;
  localparam int NUM_EQ_DEF = 3;
  localparam logic [15:0] SEED_DEF = 16'hACE1;
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10
  } op_e;
  typedef enum logic [2:0] {
    IDLE,
    GEN,
    WAIT_GO,
    CHECK,
    FINISHED
  } state_e;
  typedef struct packed {
    op_e        op;
    logic [6:0] a;
    logic [6:0] b;
    logic [6:0] result;
  } eq_t;
  // Fibonacci step, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  // Keeps multiplier operands at 11 or below so the product fits in 7 bits
  function automatic logic [3:0] mul_fold(input logic [3:0] v);
    return (v >= 4'd12) ? v - 4'd4 : v;
  endfunction
  // Turns one LFSR snapshot into an equation; 11 in the opcode field maps to add
  function automatic eq_t gen_eq(input logic [15:0] l);
    eq_t e;
    logic [6:0] x, y, m, n;
    x = {1'b0, l[7:2]};
    y = {1'b0, l[13:8]};
    m = {3'b0, mul_fold(l[5:2])};
    n = {3'b0, mul_fold(l[11:8])};
    e.op = (l[1:0] == 2'b11) ? OP_ADD : op_e'(l[1:0]);
    e.a = (e.op == OP_MUL) ? m : (e.op == OP_SUB && x < y) ? y : x;
    e.b = (e.op == OP_MUL) ? n : (e.op == OP_SUB && x < y) ? x : y;
    e.result = (e.op == OP_MUL) ? m * n : (e.op == OP_SUB) ? e.a - e.b : e.a + e.b;
    return e;
  endfunction
endpackage

// File: rtl/equation_checker_if.sv
// equation_checker_if: control, answer and display signals between the game FSM and the checker
interface equation_checker_if #(parameter int DATA_W = 7);
  logic              Start;
  logic              Enable;
  logic              Go;
  logic [DATA_W-1:0] DataIn;
  logic [DATA_W-1:0] OpA;
  logic [DATA_W-1:0] OpB;
  logic [1:0]        OpCode;
  logic [1:0]        EqNum;
  logic              correct;
  logic              WrongPulse;
  logic              Wrong;
  logic [3:0]        WrongCount;
  logic              RoundDone;
  modport master (
    output Start, Enable, Go, DataIn,
    input  OpA, OpB, OpCode, EqNum, correct, WrongPulse, Wrong, WrongCount, RoundDone
  );
  modport slave (
    input  Start, Enable, Go, DataIn,
    output OpA, OpB, OpCode, EqNum, correct, WrongPulse, Wrong, WrongCount, RoundDone
  );
endinterface

// File: rtl/equation_checker_go_key_sync.sv
// go_key_sync: two-flop synchroniser for an active-low key plus a one-shot falling-edge detect
module go_key_sync (
  input  logic Clock,
  input  logic Resetn,
  input  logic key_n,
  output logic go_fall
);
  logic s1, s2, s3;
  // Flops idle high (key released) so leaving reset never fakes a press
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign go_fall = s3 & ~s2;
endmodule

// File: rtl/equation_checker.sv
// equation_checker: generates NUM_EQ equations per round and grades the answers keyed in with Go
module equation_checker
  import equation_checker_pkg::*;
#(
  parameter int          DATA_W = DATA_W_DEF,
  parameter int          NUM_EQ = NUM_EQ_DEF,
  parameter logic [15:0] SEED   = SEED_DEF
) (
  input logic Clock,
  input logic Resetn,
  equation_checker_if.slave bus
);
  state_e            state;
  logic [15:0]       lfsr;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] answer;
  logic              go_fall;
  eq_t               eq;
  go_key_sync u_go_key_sync (
    .Clock  (Clock),
    .Resetn (Resetn),
    .key_n  (bus.Go),
    .go_fall(go_fall)
  );
  assign eq = gen_eq(lfsr);
  // Free-running LFSR so the equation depends on when the player pressed Start
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) lfsr <= SEED;
    else lfsr <= lfsr_next(lfsr);
  end
  // Round FSM; Start overrides everything, pulses default low every cycle
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state          <= IDLE;
      expected       <= '0;
      answer         <= '0;
      bus.OpA        <= '0;
      bus.OpB        <= '0;
      bus.OpCode     <= 2'b00;
      bus.EqNum      <= 2'd0;
      bus.correct    <= 1'b0;
      bus.WrongPulse <= 1'b0;
      bus.Wrong      <= 1'b0;
      bus.WrongCount <= 4'd0;
      bus.RoundDone  <= 1'b0;
    end else begin
      bus.correct    <= 1'b0;
      bus.WrongPulse <= 1'b0;
      bus.RoundDone  <= 1'b0;
      if (bus.Start) begin
        state          <= GEN;
        bus.EqNum      <= 2'd0;
        bus.Wrong      <= 1'b0;
        bus.WrongCount <= 4'd0;
      end else begin
        case (state)
          GEN: begin
            bus.OpA    <= DATA_W'(eq.a);
            bus.OpB    <= DATA_W'(eq.b);
            bus.OpCode <= eq.op;
            expected   <= DATA_W'(eq.result);
            state      <= WAIT_GO;
          end
          WAIT_GO: begin
            if (go_fall && bus.Enable) begin
              answer <= bus.DataIn;
              state  <= CHECK;
            end
          end
          CHECK: begin
            if (answer == expected) begin
              bus.correct <= 1'b1;
              if (bus.EqNum == 2'(NUM_EQ - 1)) begin
                bus.RoundDone <= 1'b1;
                state         <= FINISHED;
              end else begin
                bus.EqNum <= bus.EqNum + 2'd1;
                state     <= GEN;
              end
            end else begin
              bus.WrongPulse <= 1'b1;
              bus.Wrong      <= 1'b1;
              bus.WrongCount <= bus.WrongCount + {3'b0, bus.WrongCount != 4'hF};
              state          <= WAIT_GO;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
